// File: rtl/svn_pkg.sv
// Shared constants for the seven-segment display path: active-high hex glyphs,
// the all-off pattern and the output polarity helper.
package svn_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Bit order {g,f,e,d,c,b,a}, 1 = segment lit.
   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [6:0] seg_pol(input logic [6:0] seg_hi, input bit active_low);
      return active_low ? ~seg_hi : seg_hi;
   endfunction

endpackage

// File: rtl/svn_hex_decoder.sv
// Combinational nibble-to-glyph decoder with a forced-blank input.
module svn_hex_decoder
   import svn_pkg::*;
(
   input  logic [3:0] i_value,
   input  logic       i_blank,
   output logic [6:0] o_seg
);

   // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      o_seg = GLYPH[i_value];
      if (i_blank) o_seg = SEG_BLANK;
   end

endmodule

// File: rtl/svn_display_mux.sv
// Time-multiplexed seven-segment scanner with periodic/forced snapshots,
// decimal point, leading-zero blanking and whole-display blink.
module svn_display_mux
   import svn_pkg::*;
#(
   parameter  int NUM_DIGITS = 4,
   parameter  int SCAN_DIV   = 48000,
   parameter  int UPDATE_DIV = 6000000,
   parameter  bit ACTIVE_LOW = 1'b1,
   localparam int IW         = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [IW-1:0]           dp_pos,
   input  logic                    dp_en,
   input  logic                    blank_lz,
   input  logic                    blink_en,
   input  logic                    load,
   output logic [NUM_DIGITS-1:0]   en,
   output logic [6:0]              svn_conf,
   output logic                    DP,
   output logic                    update_tick
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam int UW = $clog2(UPDATE_DIV);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [UW-1:0] UPD_LAST  = UW'(UPDATE_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   logic [SW-1:0]           r_scan_cnt;
   logic [UW-1:0]           r_upd_cnt;
   logic [IW-1:0]           r_idx;
   logic                    r_phase;
   logic [4*NUM_DIGITS-1:0] r_digits;
   logic [IW-1:0]           r_dp_pos;
   logic                    r_dp_en;
   logic                    r_tick;
   logic [NUM_DIGITS-1:0]   r_en;
   logic [6:0]              r_seg;
   logic                    r_dp;

   logic                    w_scan_wrap;
   logic                    w_upd_tc;
   logic                    w_snap;
   logic [3:0]              w_nib;
   logic [IW-1:0]           w_eff_pt;
   logic [NUM_DIGITS-1:0]   w_tail_zero;
   logic                    w_blink_off;
   logic                    w_lz_blank;
   logic                    w_dp_hi;
   logic [6:0]              w_seg_hi;
   logic [NUM_DIGITS-1:0]   w_onehot;

   assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);
   assign w_upd_tc    = (r_upd_cnt == UPD_LAST);
   assign w_snap      = w_upd_tc | load;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan_cnt <= '0;
         r_upd_cnt  <= '0;
         r_idx      <= '0;
         r_phase    <= 1'b0;
         r_digits   <= '0;
         r_dp_pos   <= '0;
         r_dp_en    <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SW'(1);
         if (w_scan_wrap) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
         r_upd_cnt <= w_snap ? '0 : r_upd_cnt + UW'(1);
         if (w_snap) begin
            r_digits <= digits_in;
            r_dp_pos <= dp_pos;
            r_dp_en  <= dp_en;
         end
         // Only the free-running period drives blink; a forced load leaves the phase alone.
         if (w_upd_tc) r_phase <= ~r_phase;
         r_tick <= w_snap;
      end
   end

   // w_tail_zero[k] = snapshot digits k..NUM_DIGITS-1 are all zero.
   always_comb begin
      logic zero_run;
      zero_run    = 1'b1;
      w_tail_zero = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run       = zero_run & (r_digits[4*k +: 4] == 4'h0);
         w_tail_zero[k] = zero_run;
      end
   end

   assign w_nib       = r_digits[4*int'(r_idx) +: 4];
   assign w_eff_pt    = r_dp_en ? r_dp_pos : '0;
   assign w_blink_off = blink_en & r_phase;
   assign w_lz_blank  = blank_lz & (r_idx > w_eff_pt) & w_tail_zero[r_idx];
   assign w_dp_hi     = r_dp_en & (r_idx == r_dp_pos) & ~w_blink_off & ~w_lz_blank;

   always_comb begin
      w_onehot = '0;
      if (!w_blink_off) w_onehot[r_idx] = 1'b1;
   end

   svn_hex_decoder u_dec (
      .i_value (w_nib),
      .i_blank (w_lz_blank | w_blink_off),
      .o_seg   (w_seg_hi)
   );

   // Enable, segments and DP share one register stage so they always switch on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en  <= ACTIVE_LOW ? '1 : '0;
         r_seg <= seg_pol(SEG_BLANK, ACTIVE_LOW);
         r_dp  <= ACTIVE_LOW;
      end else begin
         r_en  <= ACTIVE_LOW ? ~w_onehot : w_onehot;
         r_seg <= seg_pol(w_seg_hi, ACTIVE_LOW);
         r_dp  <= w_dp_hi ^ ACTIVE_LOW;
      end
   end

   assign en          = r_en;
   assign svn_conf    = r_seg;
   assign DP          = r_dp;
   assign update_tick = r_tick;

endmodule

// File: tb/tb_svn_display_mux.sv
// Directed bench for svn_display_mux: glyph/blanking vector table plus
// edge-numbered sequences for reset, snapshot, load, blink and coincidence.
module tb_svn_display_mux;

   logic        clk;
   logic        rst_n;
   logic [15:0] digits_in;
   logic [1:0]  dp_pos;
   logic        dp_en;
   logic        blank_lz;
   logic        blink_en;
   logic        load;
   logic [3:0]  en;
   logic [6:0]  svn_conf;
   logic        DP;
   logic        update_tick;

   int n_checks  = 0;
   int n_errors  = 0;
   int n         = 0;   // posedges since last reset release
   int tick_count = 0;

   typedef struct {
      logic [15:0]     digits;
      logic [1:0]      dp_pos;
      logic            dp_en;
      logic            blank_lz;
      logic [3:0][6:0] seg;   // expected active-low glyph per digit
      logic [3:0]      dp;    // expected DP level per digit
   } vec_t;

   vec_t vecs [8];

   svn_display_mux #(
      .NUM_DIGITS (4),
      .SCAN_DIV   (4),
      .UPDATE_DIV (64),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .digits_in   (digits_in),
      .dp_pos      (dp_pos),
      .dp_en       (dp_en),
      .blank_lz    (blank_lz),
      .blink_en    (blink_en),
      .load        (load),
      .en          (en),
      .svn_conf    (svn_conf),
      .DP          (DP),
      .update_tick (update_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      n++;
      if (update_tick === 1'b1) tick_count++;
   endtask

   task automatic go_to(input int edge_no);
      while (n < edge_no) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      load  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n      = 1'b1;
      n          = 0;
      tick_count = 0;
   endtask

   initial begin
      logic [3:0] exp_en;
      bit   [3:0] seen;
      int         cnt;

      digits_in = 16'h0000;
      dp_pos    = 2'd0;
      dp_en     = 1'b0;
      blank_lz  = 1'b0;
      blink_en  = 1'b0;
      load      = 1'b0;

      vecs[0] = '{16'h0005, 2'd1, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h40, 7'h12}, 4'b1101};
      vecs[1] = '{16'h0005, 2'd1, 1'b1, 1'b0, {7'h40, 7'h40, 7'h40, 7'h12}, 4'b1101};
      vecs[2] = '{16'h0000, 2'd2, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
      vecs[3] = '{16'h0A0F, 2'd0, 1'b0, 1'b1, {7'h7F, 7'h08, 7'h40, 7'h0E}, 4'b1111};
      vecs[4] = '{16'h8E6C, 2'd3, 1'b1, 1'b1, {7'h00, 7'h06, 7'h02, 7'h46}, 4'b0111};
      vecs[5] = '{16'h0B07, 2'd0, 1'b1, 1'b1, {7'h7F, 7'h03, 7'h40, 7'h78}, 4'b1110};
      vecs[6] = '{16'h9D03, 2'd2, 1'b0, 1'b0, {7'h10, 7'h21, 7'h40, 7'h30}, 4'b1111};
      vecs[7] = '{16'h0020, 2'd3, 1'b1, 1'b1, {7'h40, 7'h40, 7'h24, 7'h40}, 4'b0111};

      // Reset state and scan order
      do_reset();
      check("rst_en",   en,          4'b1111);
      check("rst_seg",  svn_conf,    7'h7F);
      check("rst_dp",   DP,          1'b1);
      check("rst_tick", update_tick, 1'b0);
      for (int e = 1; e <= 20; e++) begin
         tick();
         exp_en = 4'b0001 << (((e - 1) / 4) % 4);
         exp_en = ~exp_en;
         check($sformatf("scan_en_%0d", e), en, exp_en);
      end
      check("scan_seg_zero", svn_conf, 7'h40);

      // Asynchronous reset mid-scan
      rst_n = 1'b0;
      #1;
      check("midrst_en",   en,          4'b1111);
      check("midrst_seg",  svn_conf,    7'h7F);
      check("midrst_dp",   DP,          1'b1);
      check("midrst_tick", update_tick, 1'b0);

      // Glyph / DP / blanking table
      do_reset();
      for (int i = 0; i < 8; i++) begin
         digits_in = vecs[i].digits;
         dp_pos    = vecs[i].dp_pos;
         dp_en     = vecs[i].dp_en;
         blank_lz  = vecs[i].blank_lz;
         load      = 1'b1;
         tick();
         load = 1'b0;
         seen = '0;
         for (int s = 0; s < 16; s++) begin
            tick();
            for (int d = 0; d < 4; d++) begin
               exp_en = 4'b0001 << d;
               if (en == ~exp_en && !seen[d]) begin
                  seen[d] = 1'b1;
                  check($sformatf("v%0d_seg%0d", i, d), svn_conf, vecs[i].seg[d]);
                  check($sformatf("v%0d_dp%0d", i, d), DP, vecs[i].dp[d]);
               end
            end
         end
         check($sformatf("v%0d_all_digits", i), seen, 4'hF);
      end

      // Snapshot, load, blink, coincidence on absolute edge numbers
      digits_in = 16'h1234;
      dp_en     = 1'b0;
      blank_lz  = 1'b0;
      blink_en  = 1'b0;
      do_reset();
      load = 1'b1;
      tick();
      load = 1'b0;
      check("load_tick", update_tick, 1'b1);
      go_to(2);
      check("snap_d0_seg", svn_conf, 7'h19);
      check("snap_d0_en",  en,       4'b1110);
      go_to(10);
      digits_in = 16'h5678;
      go_to(60);
      check("hold_d2_seg", svn_conf, 7'h24);
      check("hold_d2_en",  en,       4'b1011);
      go_to(64);
      check("no_early_tick", tick_count, 1);
      go_to(65);
      check("tc_tick",    update_tick, 1'b1);
      check("tc_old_seg", svn_conf,    7'h19);
      go_to(66);
      check("tc_new_seg",  svn_conf,    7'h00);
      check("tc_new_en",   en,          4'b1110);
      check("tc_tick_low", update_tick, 1'b0);

      go_to(84);
      digits_in = 16'h0009;
      load      = 1'b1;
      tick();
      load = 1'b0;
      check("load2_tick", update_tick, 1'b1);
      check("load2_count", tick_count, 3);
      go_to(90);
      blink_en = 1'b1;
      cnt = 0;
      while (n < 149) begin
         tick();
         if (n >= 92 && en != 4'b1111) cnt++;
      end
      check("blink_off_period", cnt, 0);
      check("load_restart_tick", update_tick, 1'b1);
      check("load_restart_count", tick_count, 4);
      cnt = 0;
      while (n < 213) begin
         tick();
         if (en == 4'b1111) cnt++;
      end
      check("blink_on_period", cnt, 0);
      check("blink_tick", update_tick, 1'b1);
      go_to(214);
      check("blink_off_again", en, 4'b1111);

      go_to(276);
      load = 1'b1;
      tick();
      load = 1'b0;
      check("coin_tick", update_tick, 1'b1);
      check("coin_count", tick_count, 6);
      go_to(278);
      check("coin_tick_low", update_tick, 1'b0);
      check("coin_phase_en", en, 4'b1101);
      go_to(340);
      check("coin_restart", tick_count, 6);
      go_to(341);
      check("coin_next_tick", update_tick, 1'b1);
      go_to(342);
      check("coin_next_blink", en, 4'b1111);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/svn_display_mux.md
Name: svn_display_mux

Overview:
Parametrised time-multiplexed 7-segment driver for the oscilloscope front panel. It is the next-generation digit scanner. It drives NUM_DIGITS common-enable digits from a packed BCD/hex bus, with these features:
- periodic snapshot of the displayed value, with a working update-counter restart;
- on-demand reload;
- programmable decimal-point position;
- leading-zero blanking;
- whole-display blink.

It sits between the measurement/formatting logic and the board's seven-segment pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (legal 2..8).
SCAN_DIV, 48000, clk cycles per digit slot; must be >= 2.
UPDATE_DIV, 6000000, clk cycles between automatic snapshots (0.5 s at 12 MHz); must be >= 2.
ACTIVE_LOW, 1, 1 = segment, enable and DP outputs are lit/selected at 0; 0 = lit/selected at 1.
Derived: IW = max(1, clog2(NUM_DIGITS)).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
digits_in  in  4*NUM_DIGITS  nibble k = digit k; digit 0 is rightmost.
dp_pos  in  IW  index of the digit whose DP is lit.
dp_en  in  1  1 = DP shown at dp_pos; 0 = no DP.
blank_lz  in  1  enable leading-zero blanking.
blink_en  in  1  enable blink.
load  in  1  single-cycle request to snapshot immediately.
en  out  NUM_DIGITS  digit enables (one-hot, polarity per ACTIVE_LOW).
svn_conf  out  7  segments {g,f,e,d,c,b,a}.
DP  out  1  decimal point segment.
update_tick  out  1  one-cycle pulse on every snapshot.

Behaviour:
- Reset (async assert, sync release):
  - scan counter, update counter, digit index and blink phase all = 0;
  - snapshot registers = 0;
  - en all deselected; svn_conf all unlit; DP unlit; update_tick = 0.
- Scan counter:
  - counts 0..SCAN_DIV-1, then wraps to 0;
  - on the wrap cycle, the digit index increments 0..NUM_DIGITS-1 and wraps to 0.
  - Every digit therefore gets exactly SCAN_DIV cycles, with no dead slot.
- Update counter:
  - counts 0..UPDATE_DIV-1; terminal count generates a snapshot and returns the counter to 0.
  - load = 1 also generates a snapshot and forces the counter to 0.
  - If load coincides with terminal count, exactly one snapshot occurs and the counter goes to 0.
- Snapshot: digits_in, dp_pos and dp_en are captured in registers, and update_tick pulses high in the same cycle the registers load.
  - The display only ever shows snapshot values.
  - Input changes between snapshots are invisible.
- Blink phase toggles on every snapshot caused by the terminal count, but not on load-only snapshots.
  - When blink_en = 1 and phase = 1, all en are deselected; the counters keep running.
  - When blink_en = 0, the phase still toggles but is ignored.
- Leading-zero blanking: digit k is blanked (en stays selected, svn_conf all unlit, DP unlit) when all of the following hold:
  - blank_lz = 1;
  - k > effective point position (the snapshot dp_pos if dp_en, else 0);
  - snapshot digits k..NUM_DIGITS-1 are all zero.
  - The digit at the effective point position and all digits below it are never blanked.
  - Example: 0.05 is shown as "0.05", not ".05".
- Glyphs: standard hex table for 0-F. Active-high patterns (before polarity):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - The outputs are inverted when ACTIVE_LOW = 1.
- DP is lit only when dp_en = 1, the current index equals the snapshot dp_pos, and the digit is not blinked off.
  - dp_pos >= NUM_DIGITS means no DP is shown.
- Output timing: en, svn_conf and DP are registered. They reflect the new digit index exactly 1 cycle after the scan wrap.
  - en, svn_conf and DP change together in that cycle, with no cycle of mismatched enable and segment data.
- Reset mid-operation: all outputs immediately return to their reset values. After release, scanning restarts at digit 0 with snapshot = 0 until the first snapshot.

Decomposition:
- Package svn_pkg holds:
  - the 16-entry active-high glyph constant table;
  - the SEG_BLANK constant;
  - a polarity helper function.
- One combinational sub-module, svn_hex_decoder (4-bit value plus blank input, 7-bit active-high segments out), instantiated once on the muxed nibble.
- Counters, snapshot, blanking and blink logic stay in svn_display_mux.

Test Plan:
Use NUM_DIGITS=4, SCAN_DIV=4, UPDATE_DIV=64 and ACTIVE_LOW=1 unless stated otherwise.
1. Reset: assert rst_n=0 mid-scan -> en=4'b1111, svn_conf=7'h7F, DP=1 immediately. After release, the first selected en=4'b1110, and each digit holds for exactly 4 cycles in the order 1110, 1101, 1011, 0111, then wraps to 1110.
2. Snapshot: digits_in=16'h1234 at t=0, changed to 16'h5678 at t=10 -> display stays 1234 until the terminal count at cycle 63. update_tick pulses once, and the next scan shows 5678 (digit 0 glyph = ~7F = 7'h00).
3. load: pulse load at cycle 20 with digits_in=16'h0009 -> snapshot at cycle 20, the update counter restarts, the next terminal tick is 64 cycles later, and the blink phase is unchanged.
4. Blanking: digits_in=16'h0005, dp_en=1, dp_pos=1, blank_lz=1 -> digits 3 and 2 show svn_conf=7'h7F, digit 1 shows "0" with DP=0 (lit), and digit 0 shows "5". Repeat with blank_lz=0 -> "0005" is shown.
5. Blink: blink_en=1 -> en=4'b1111 for an entire 64-cycle update period in alternating periods, with scanning and update_tick unaffected.
6. Coincidence: load asserted on the terminal-count cycle -> exactly one update_tick, the counter goes to 0, and the blink phase toggles once.
